jtframe_prog_resp: RTL and testbench
====================================

# jtframe_prog_resp

Responder end of the JTFRAME `prog_*` bus: the download/ROM-load logic issues `prog_we`/`prog_rd`, and this block answers with `prog_ack`, `prog_dst`, `prog_dok` and `prog_rdy`. It executes each command on a single generic word-memory port (`mem_*`) that faces the SDRAM controller. It sits between the game's programming logic and the SDRAM, and replaces the controller's built-in programming path for cores that need readback and error reporting.

## Interface

Parameters:
- `AW`, 22: `prog_addr` width in 16-bit words (23 for `JTFRAME_SDRAM_LARGE`).
- `BURST`, 1: words returned per read; legal values are 1 or 2.
- `TOUT`, 255: watchdog limit in cycles for the WAIT state (8-bit counter).

Ports:
- `clk` in 1: single clock, the SDRAM/game clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `prog_addr` in AW: word address.
- `prog_ba` in 2: SDRAM bank.
- `prog_data` in 16: write data.
- `prog_mask` in 2: byte mask, active-low (0 = write that byte).
- `prog_we` in 1: write request, level, held until `prog_rdy`.
- `prog_rd` in 1: read request, level, held until `prog_rdy`.
- `prog_ack` out 1: one-cycle pulse when the memory has accepted the command.
- `prog_dst` out 1: one-cycle pulse with the first read word.
- `prog_dok` out 1: high on every cycle where `prog_dout` carries a new valid word.
- `prog_rdy` out 1: one-cycle pulse when the command is complete.
- `prog_dout` out 16: read data, registered.
- `prog_err` out 1: sticky watchdog error flag, cleared only by reset.
- `mem_req` out 1: memory request, held until `mem_gnt`.
- `mem_wr` out 1: 1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr` out AW+2: `{prog_ba, prog_addr}`, latched.
- `mem_din` out 16: write data, latched.
- `mem_mask` out 2: byte mask, latched.
- `mem_gnt` in 1: one-cycle acceptance pulse from memory.
- `mem_dvalid` in 1: read word valid on `mem_dout`.
- `mem_dout` in 16: read data from memory.
- `mem_done` in 1: write completion pulse from memory.

## Operation

- FSM states: IDLE, REQ, WAIT, DONE, GUARD.
- IDLE:
  - `prog_we` or `prog_rd` sampled high: latch address, bank, data, mask and direction; go to REQ.
  - Both high together: the write is served first. The read stays pending and is served after GUARD if the requester still holds it.
- REQ: hold `mem_req`=1. On `mem_gnt`, drop `mem_req`, pulse `prog_ack` on the next cycle, clear the watchdog counter, go to WAIT.
- WAIT, write: `mem_done` leads to DONE.
- WAIT, read:
  - Each `mem_dvalid` registers `mem_dout` into `prog_dout` and raises `prog_dok` on the next cycle.
  - The first word also pulses `prog_dst`.
  - After BURST words, go to DONE.
  - `mem_dvalid` arriving before `mem_gnt` is ignored.
- DONE: `prog_rdy`=1 for one cycle, then GUARD.
- GUARD: one cycle in which requests are ignored, so a request the requester is still dropping is not re-issued. Then IDLE.
- Watchdog: counts in REQ and WAIT. On reaching TOUT it sets `prog_err`, drops `mem_req`, and goes to DONE, so the requester never hangs. `prog_dout` keeps its last value in that case.
- Latched command fields do not change between IDLE exit and DONE, even if `prog_*` inputs change.
- A request deasserted before acceptance is not cancelled; the command completes normally.

## Timing

- Reset values: every output is 0, `prog_dout`=0, `mem_addr`/`mem_din`=0, `mem_mask`=2'b11, state IDLE, watchdog counter 0.
- Reset asserted mid-command drops `mem_req` immediately (asynchronously). No `prog_rdy` is produced for the aborted command.
- Request sampled at cycle 0: `mem_req` is high from cycle 1.
- `mem_gnt` at cycle g: `prog_ack` at g+1.
- Write with `mem_done` at cycle d: `prog_rdy` at d+1.
- Read with `mem_dvalid` at cycle v: `prog_dout`/`prog_dok`(/`prog_dst`) at v+1. `prog_rdy` follows at v+2 after the last word.
- Minimum spacing between two commands: `prog_rdy` cycle, then GUARD, then IDLE sample. The next `mem_req` rises at the earliest 3 cycles after `prog_rdy`.
- Zero-wait memory (`mem_gnt` in cycle 1, `mem_done` in cycle 2): `prog_rdy` at cycle 3.

## Structure

- Shared package `jtframe_prog_pkg`: state enum (IDLE/REQ/WAIT/DONE/GUARD) and the default TOUT constant.
- Sub-module `jtframe_prog_wdog`: the loadable 8-bit watchdog counter with a terminal-count output.
- Everything else stays in one FSM module.

## Test plan

- Write: addr=0x1234, ba=2, data=0xBEEF, mask=2'b00; `mem_gnt` at cycle 3, `mem_done` at cycle 6 -> `mem_addr`=0x801234, `prog_ack` at 4, `prog_rdy` at 7, one `mem_req` only.
- Read, BURST=2: `mem_dvalid` at cycles 5 and 6 with 0xA5A5 and 0x5A5A -> `prog_dst` at 6, `prog_dok` at 6 and 7, `prog_dout` 0xA5A5 then 0x5A5A, `prog_rdy` at 8.
- `prog_we` and `prog_rd` high together, held -> the write completes first; then the read issues after GUARD with `mem_wr`=0.
- `mem_gnt` never asserted, TOUT=255 -> `mem_req` drops and `prog_rdy` pulses 256 cycles after `mem_req` rose; `prog_err`=1 and stays 1.
- `rst_n` low during WAIT -> `mem_req`=0 and outputs at reset values at once; no `prog_rdy`; a new write after release completes normally.
- `prog_we` held one cycle past `prog_rdy` -> no second `mem_req` is issued.

Source files
------------

// File: rtl/jtframe_prog_pkg.sv
// Shared definitions for the JTFRAME prog_* responder.
// Contents:
//   prog_state_t : responder FSM states (IDLE/REQ/WAIT/DONE/GUARD)
//   TOUT_DEF     : default watchdog limit in cycles
//   is_busy()    : true while a command is outstanding at the memory port
package jtframe_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_GUARD = 3'd4
    } prog_state_t;

    localparam int TOUT_DEF = 255;

    // The watchdog runs only while the memory owes us a grant or a completion
    function automatic logic is_busy(input prog_state_t st);
        return (st == ST_REQ) || (st == ST_WAIT);
    endfunction

endpackage

// File: rtl/jtframe_prog_wdog.sv
// Loadable 8-bit watchdog counter.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : load the counter with zero (wins over en)
//   en         : count one step per cycle; the counter saturates at TOUT
//   tc         : registered terminal count, high while the count equals TOUT
module jtframe_prog_wdog
    import jtframe_prog_pkg::*;
#(
    parameter int TOUT = TOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TOUT_C = TOUT[7:0];

    logic [7:0] cnt_r;
    logic [7:0] cnt_s;
    logic       tc_r;

    // Next count: clear, step, or hold once the limit has been reached
    always_comb begin
        cnt_s = cnt_r;
        if (clr) begin
            cnt_s = 8'd0;
        end else if (en && !tc_r) begin
            cnt_s = cnt_r + 8'd1;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Counter register; tc is registered from the same next value so it
    // always matches the count held in cnt_r
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
            tc_r  <= (TOUT_C == 8'd0);
        end else begin
            cnt_r <= cnt_s;
            tc_r  <= (cnt_s == TOUT_C);
        end
    end

    assign tc = tc_r;

endmodule

// File: rtl/jtframe_prog_resp.sv
// Responder end of the JTFRAME prog_* bus. Each prog_we/prog_rd command is
// latched and executed on a generic word-memory port facing the SDRAM.
// Ports:
//   prog_addr/ba/data/mask, prog_we, prog_rd : command from the loader
//   prog_ack  : pulse, memory accepted the command
//   prog_dst  : pulse with the first read word
//   prog_dok  : high on every cycle prog_dout carries a new word
//   prog_rdy  : pulse, command complete (also after a watchdog timeout)
//   prog_dout : registered read data
//   prog_err  : sticky watchdog flag, cleared only by reset
//   mem_*     : request/grant memory port, fields latched at command start
module jtframe_prog_resp
    import jtframe_prog_pkg::*;
#(
    parameter int AW    = 22,
    parameter int BURST = 1,
    parameter int TOUT  = TOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] prog_addr,
    input  logic [1:0]    prog_ba,
    input  logic [15:0]   prog_data,
    input  logic [1:0]    prog_mask,
    input  logic          prog_we,
    input  logic          prog_rd,
    output logic          prog_ack,
    output logic          prog_dst,
    output logic          prog_dok,
    output logic          prog_rdy,
    output logic [15:0]   prog_dout,
    output logic          prog_err,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [AW+1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_mask,
    input  logic          mem_gnt,
    input  logic          mem_dvalid,
    input  logic [15:0]   mem_dout,
    input  logic          mem_done
);

    localparam logic [1:0] LAST_W = 2'(BURST - 1);

    prog_state_t   state_r;
    logic          ack_r, dst_r, dok_r, rdy_r, err_r;
    logic [15:0]   dout_r;
    logic          req_r, wr_r;
    logic [AW+1:0] addr_r;
    logic [15:0]   din_r;
    logic [1:0]    mask_r;
    logic [1:0]    word_cnt_r;
    logic          rd_last_r;   // last burst word seen, rdy goes out next cycle

    logic wd_clr_s, wd_en_s, wd_tc_s;

    // Watchdog control: run in REQ/WAIT, restart when the grant arrives
    always_comb begin
        wd_en_s  = is_busy(state_r);
        wd_clr_s = 1'b0;
        if (!wd_en_s) begin
            wd_clr_s = 1'b1;
        end else if ((state_r == ST_REQ) && mem_gnt) begin
            wd_clr_s = 1'b1;
        end else begin
            wd_clr_s = 1'b0;
        end
    end

    jtframe_prog_wdog #(.TOUT(TOUT)) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr_s),
        .en    (wd_en_s),
        .tc    (wd_tc_s)
    );

    // Command FSM with all bus outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ack_r      <= 1'b0;
            dst_r      <= 1'b0;
            dok_r      <= 1'b0;
            rdy_r      <= 1'b0;
            err_r      <= 1'b0;
            dout_r     <= 16'h0000;
            req_r      <= 1'b0;
            wr_r       <= 1'b0;
            addr_r     <= '0;
            din_r      <= 16'h0000;
            mask_r     <= 2'b11;
            word_cnt_r <= 2'd0;
            rd_last_r  <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            dst_r <= 1'b0;
            dok_r <= 1'b0;
            rdy_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A simultaneous read stays with the requester and is
                    // picked up again once this write has gone through GUARD
                    if (prog_we || prog_rd) begin
                        addr_r     <= {prog_ba, prog_addr};
                        din_r      <= prog_data;
                        mask_r     <= prog_mask;
                        wr_r       <= prog_we;
                        req_r      <= 1'b1;
                        word_cnt_r <= 2'd0;
                        rd_last_r  <= 1'b0;
                        state_r    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        req_r   <= 1'b0;
                        ack_r   <= 1'b1;
                        state_r <= ST_WAIT;
                    end else if (wd_tc_s) begin
                        req_r   <= 1'b0;
                        err_r   <= 1'b1;
                        rdy_r   <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (wr_r) begin
                        if (mem_done) begin
                            rdy_r   <= 1'b1;
                            state_r <= ST_DONE;
                        end else if (wd_tc_s) begin
                            err_r   <= 1'b1;
                            rdy_r   <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else if (rd_last_r) begin
                        // rdy follows the last prog_dok by one cycle
                        rdy_r   <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (mem_dvalid) begin
                        dout_r     <= mem_dout;
                        dok_r      <= 1'b1;
                        dst_r      <= (word_cnt_r == 2'd0);
                        word_cnt_r <= word_cnt_r + 2'd1;
                        rd_last_r  <= (word_cnt_r == LAST_W);
                    end else if (wd_tc_s) begin
                        err_r   <= 1'b1;
                        rdy_r   <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_GUARD;
                end
                ST_GUARD: begin
                    // Requests are ignored here so a level still being
                    // dropped by the requester is not taken as a new command
                    state_r <= ST_IDLE;
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign prog_ack  = ack_r;
    assign prog_dst  = dst_r;
    assign prog_dok  = dok_r;
    assign prog_rdy  = rdy_r;
    assign prog_dout = dout_r;
    assign prog_err  = err_r;
    assign mem_req   = req_r;
    assign mem_wr    = wr_r;
    assign mem_addr  = addr_r;
    assign mem_din   = din_r;
    assign mem_mask  = mask_r;

endmodule

// File: tb/tb_jtframe_prog_resp.sv
// Self-checking bench for jtframe_prog_resp (AW=22, BURST=2, TOUT=255).
// Each scenario describes one command as a cycle plan relative to the cycle
// in which the request is first sampled (cycle 0): grant cycle, completion
// cycle, read-valid cycles. Expected outputs per cycle are derived from the
// responder's timing rules by plain arithmetic on that plan.
module tb_jtframe_prog_resp;

    localparam int AW   = 22;
    localparam int TOUT = 255;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] prog_addr;
    logic [1:0]    prog_ba;
    logic [15:0]   prog_data;
    logic [1:0]    prog_mask;
    logic          prog_we, prog_rd;
    logic          prog_ack, prog_dst, prog_dok, prog_rdy, prog_err;
    logic [15:0]   prog_dout;
    logic          mem_req, mem_wr;
    logic [AW+1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [1:0]    mem_mask;
    logic          mem_gnt, mem_dvalid, mem_done;
    logic [15:0]   mem_dout;

    jtframe_prog_resp #(.AW(AW), .BURST(2), .TOUT(TOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_addr  (prog_addr),
        .prog_ba    (prog_ba),
        .prog_data  (prog_data),
        .prog_mask  (prog_mask),
        .prog_we    (prog_we),
        .prog_rd    (prog_rd),
        .prog_ack   (prog_ack),
        .prog_dst   (prog_dst),
        .prog_dok   (prog_dok),
        .prog_rdy   (prog_rdy),
        .prog_dout  (prog_dout),
        .prog_err   (prog_err),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_mask   (mem_mask),
        .mem_gnt    (mem_gnt),
        .mem_dvalid (mem_dvalid),
        .mem_dout   (mem_dout),
        .mem_done   (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Current plan
    int          p_wr, p_g, p_d, p_v1, p_v2, p_vx, p_we_last, p_rd_last, p_n;
    bit          p_scr;
    logic [21:0] p_addr;
    logic [1:0]  p_ba, p_mask;
    logic [15:0] p_data, p_w1, p_w2;

    // Model state carried between commands
    logic [15:0] prev_dout;
    bit          prev_err;

    int  cyc;
    bit  chk_en = 1'b0;

    // Observations used by the literal checks
    int          ack_at, rdy_at, dst_at, rises;
    logic        req_prev = 1'b0;
    logic [15:0] dout_log [0:15];
    logic [31:0] addr_at2;
    logic        wr_at1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // ---- model: outputs as a function of the plan and the cycle ----
    function automatic bit e_req(input int c);
        int last;
        last = (p_g >= 0) ? p_g : TOUT + 1;
        return (c >= 1) && (c <= last);
    endfunction

    function automatic int e_rdy_cyc();
        if (p_g < 0) return TOUT + 2;
        if (p_wr != 0) return (p_d >= 0) ? p_d + 1 : -1;
        return (p_v2 >= 0) ? p_v2 + 2 : -1;
    endfunction

    function automatic bit e_dok(input int c);
        if (p_wr != 0 || p_g < 0) return 1'b0;
        return (p_v1 >= 0 && c == p_v1 + 1) || (p_v2 >= 0 && c == p_v2 + 1);
    endfunction

    function automatic bit e_dst(input int c);
        if (p_wr != 0 || p_g < 0) return 1'b0;
        return (p_v1 >= 0 && c == p_v1 + 1);
    endfunction

    function automatic logic [15:0] e_dout(input int c);
        if (p_wr == 0 && p_g >= 0 && p_v2 >= 0 && c > p_v2) return p_w2;
        if (p_wr == 0 && p_g >= 0 && p_v1 >= 0 && c > p_v1) return p_w1;
        return prev_dout;
    endfunction

    function automatic bit e_err(input int c);
        return prev_err || (p_g < 0 && c >= TOUT + 2);
    endfunction

    // Compare process: every checked cycle, all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req",   {31'd0, mem_req},  {31'd0, e_req(cyc)});
            chk("prog_ack",  {31'd0, prog_ack}, {31'd0, (p_g >= 0 && cyc == p_g + 1)});
            chk("prog_rdy",  {31'd0, prog_rdy}, {31'd0, (cyc == e_rdy_cyc())});
            chk("prog_dok",  {31'd0, prog_dok}, {31'd0, e_dok(cyc)});
            chk("prog_dst",  {31'd0, prog_dst}, {31'd0, e_dst(cyc)});
            chk("prog_dout", {16'd0, prog_dout}, {16'd0, e_dout(cyc)});
            chk("prog_err",  {31'd0, prog_err}, {31'd0, e_err(cyc)});
            if (e_req(cyc)) begin
                chk("mem_wr",   {31'd0, mem_wr}, {31'd0, (p_wr != 0)});
                chk("mem_addr", {8'd0, mem_addr}, {8'd0, p_ba, p_addr});
                if (p_wr != 0) begin
                    chk("mem_din",  {16'd0, mem_din}, {16'd0, p_data});
                    chk("mem_mask", {30'd0, mem_mask}, {30'd0, p_mask});
                end
            end
            if (prog_ack && ack_at < 0) ack_at = cyc;
            if (prog_rdy && rdy_at < 0) rdy_at = cyc;
            if (prog_dst && dst_at < 0) dst_at = cyc;
            if (mem_req && !req_prev) rises++;
            if (cyc < 16) dout_log[cyc] = prog_dout;
            if (cyc == 2) addr_at2 = {8'd0, mem_addr};
            if (cyc == 1) wr_at1 = mem_wr;
        end
        req_prev = mem_req;
    end

    task automatic set_plan(input int wr, input int g, input int d, input int v1,
                            input int v2, input int vx, input int we_last,
                            input int rd_last, input int n);
        p_wr = wr; p_g = g; p_d = d; p_v1 = v1; p_v2 = v2; p_vx = vx;
        p_we_last = we_last; p_rd_last = rd_last; p_n = n; p_scr = 1'b0;
    endtask

    task automatic set_cmd(input logic [21:0] a, input logic [1:0] ba,
                           input logic [15:0] d, input logic [1:0] m);
        p_addr = a; p_ba = ba; p_data = d; p_mask = m;
    endtask

    task automatic drive(input int c);
        prog_we    = (c <= p_we_last);
        prog_rd    = (c <= p_rd_last);
        prog_addr  = (p_scr && c > 0) ? 22'h3FFFFF : p_addr;
        prog_ba    = (p_scr && c > 0) ? ~p_ba : p_ba;
        prog_data  = (p_scr && c > 0) ? ~p_data : p_data;
        prog_mask  = (p_scr && c > 0) ? ~p_mask : p_mask;
        mem_gnt    = (c == p_g);
        mem_done   = (c == p_d);
        mem_dvalid = (c == p_v1) || (c == p_v2) || (c == p_vx);
        mem_dout   = (c == p_v1) ? p_w1 : (c == p_v2) ? p_w2 :
                     (c == p_vx) ? 16'hDEAD : 16'h0000;
    endtask

    task automatic run_plan();
        ack_at = -1; rdy_at = -1; dst_at = -1; rises = 0;
        for (int c = 0; c < p_n; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            drive(c);
            chk_en = 1'b1;
        end
        @(negedge clk);
        #1;
        chk_en    = 1'b0;
        prev_dout = e_dout(p_n - 1);
        prev_err  = e_err(p_n - 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ack"},  {31'd0, prog_ack}, 32'd0);
        chk({tag, "_dst"},  {31'd0, prog_dst}, 32'd0);
        chk({tag, "_dok"},  {31'd0, prog_dok}, 32'd0);
        chk({tag, "_rdy"},  {31'd0, prog_rdy}, 32'd0);
        chk({tag, "_dout"}, {16'd0, prog_dout}, 32'd0);
        chk({tag, "_err"},  {31'd0, prog_err}, 32'd0);
        chk({tag, "_req"},  {31'd0, mem_req}, 32'd0);
        chk({tag, "_wr"},   {31'd0, mem_wr}, 32'd0);
        chk({tag, "_addr"}, {8'd0, mem_addr}, 32'd0);
        chk({tag, "_din"},  {16'd0, mem_din}, 32'd0);
        chk({tag, "_mask"}, {30'd0, mem_mask}, 32'd3);
    endtask

    initial begin
        rst_n = 1'b0;
        prog_we = 1'b0; prog_rd = 1'b0; prog_addr = '0; prog_ba = 2'd0;
        prog_data = 16'h0000; prog_mask = 2'b11;
        mem_gnt = 1'b0; mem_dvalid = 1'b0; mem_done = 1'b0; mem_dout = 16'h0000;
        p_w1 = 16'h0000; p_w2 = 16'h0000;
        prev_dout = 16'h0000; prev_err = 1'b0; cyc = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Write, inputs scrambled after cycle 0 to show fields are latched
        set_cmd(22'h001234, 2'd2, 16'hBEEF, 2'b00);
        set_plan(1, 3, 6, -1, -1, -1, 7, -1, 10);
        p_scr = 1'b1;
        run_plan();
        chk("wr_ack_at", ack_at, 32'd4);
        chk("wr_rdy_at", rdy_at, 32'd7);
        chk("wr_req_once", rises, 32'd1);
        chk("wr_addr", addr_at2, 32'h00801234);

        // Burst read with a stray mem_dvalid before the grant
        set_cmd(22'h000100, 2'd0, 16'h0000, 2'b11);
        set_plan(0, 3, -1, 5, 6, 2, -1, 8, 11);
        p_w1 = 16'hA5A5; p_w2 = 16'h5A5A;
        run_plan();
        chk("rd_dst_at", dst_at, 32'd6);
        chk("rd_dout3", {16'd0, dout_log[3]}, 32'h0000);
        chk("rd_dout6", {16'd0, dout_log[6]}, 32'h0000A5A5);
        chk("rd_dout7", {16'd0, dout_log[7]}, 32'h00005A5A);
        chk("rd_rdy_at", rdy_at, 32'd8);

        // prog_we and prog_rd together: zero-wait write first, then the read
        set_cmd(22'h000ABC, 2'd1, 16'h1357, 2'b01);
        set_plan(1, 1, 2, -1, -1, -1, 3, 100, 5);
        run_plan();
        chk("both_wr_rdy_at", rdy_at, 32'd3);
        set_plan(0, 2, -1, 4, 5, -1, -1, 7, 10);
        p_w1 = 16'h0F0F; p_w2 = 16'hF0F0;
        run_plan();
        chk("both_rd_wr", {31'd0, wr_at1}, 32'd0);
        chk("both_rd_rdy_at", rdy_at, 32'd7);

        // prog_we held one cycle past prog_rdy: no second command
        set_cmd(22'h002000, 2'd3, 16'hCAFE, 2'b10);
        set_plan(1, 2, 3, -1, -1, -1, 5, -1, 10);
        run_plan();
        chk("hold_req_once", rises, 32'd1);
        chk("hold_rdy_at", rdy_at, 32'd4);

        // Grant never comes: watchdog ends the command
        set_cmd(22'h003000, 2'd1, 16'h7777, 2'b00);
        set_plan(1, -1, -1, -1, -1, -1, 257, -1, 260);
        run_plan();
        chk("to_rdy_at", rdy_at, 32'd257);
        chk("to_err", {31'd0, prog_err}, 32'd1);

        // Following write still works, error flag stays set
        set_cmd(22'h000042, 2'd0, 16'h4242, 2'b00);
        set_plan(1, 1, 3, -1, -1, -1, 4, -1, 7);
        run_plan();
        chk("err_sticky", {31'd0, prog_err}, 32'd1);

        // Reset in the middle of WAIT
        set_cmd(22'h000555, 2'd2, 16'h5555, 2'b00);
        set_plan(1, 2, -1, -1, -1, -1, 100, -1, 5);
        run_plan();
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        prog_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_rdy", {31'd0, prog_rdy}, 32'd0);
            chk("midrst_no_req", {31'd0, mem_req}, 32'd0);
        end
        rst_n = 1'b1;
        prev_dout = 16'h0000;
        prev_err  = 1'b0;
        set_cmd(22'h000666, 2'd1, 16'h6666, 2'b10);
        set_plan(1, 2, 4, -1, -1, -1, 5, -1, 8);
        run_plan();
        chk("after_rst_rdy_at", rdy_at, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
